dataout_rx: RTL
===============

Name: dataout_rx

Overview:
- Downstream consumer of the calculator core's serial result port (DataOut, ClkTx, DOutValid).
- Brings the nibble stream into the system Clk domain and reassembles nibbles, MSB-first, into complete result words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the scoreboard or host logic.
- Flags aborted frames and FIFO overflow.

Parameters:
- NIBBLES, 4, nibbles per result word; word width W = 4*NIBBLES (16 by default).
- DEPTH, 4, FIFO depth in words; must be a power of two and at least 2.

Ports:
- Clk  input  1  system clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ClkTx  input  1  serial transmit clock from the core, asynchronous to Clk.
- DOutValid  input  1  frame-valid from the core.
- DataOut  input  4  nibble from the core.
- WordOut  output  W  head-of-FIFO word.
- WordValid  output  1  FIFO non-empty.
- WordReady  input  1  consumer accepts WordOut when WordValid && WordReady.
- Level  output  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- RxActive  output  1  high while a frame is partially collected.
- FrameErr  output  1  one-cycle pulse when a frame is aborted.
- Overflow  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full.

Behaviour:
- Reset (Reset=0, asynchronous):
  - All synchronizers, state, FIFO pointers and outputs clear.
  - WordOut=0, WordValid=0, Level=0, RxActive=0, FrameErr=0, Overflow=0.
  - A partial frame is discarded; FIFO contents are lost.
- Input timing contract:
  - Core changes DataOut and DOutValid only on the ClkTx falling edge.
  - ClkTx high and low phases are each at least 3 Clk periods.
  - The block does not check this contract.
- Synchronization:
  - ClkTx, DOutValid and DataOut each pass through 2 flops (s1, s2); ClkTx has a third flop s3.
  - Sample strobe: rise = s2_ClkTx && !s3_ClkTx.
  - Latency: if Clk edge E0 is the first to sample ClkTx=1, rise is high between E1 and E2, and the nibble is captured at E2.
- FSM (state updates only on rise):
  - IDLE, rise && DOutValid_s: shift <= nibble, cnt <= 1, go to COLLECT. If NIBBLES=1, push immediately and stay in IDLE.
  - IDLE, rise && !DOutValid_s: ignored.
  - COLLECT, rise && DOutValid_s && cnt<NIBBLES-1: shift <= {shift[W-5:0], nibble}, cnt++.
  - COLLECT, rise && DOutValid_s && cnt==NIBBLES-1: push {shift[W-5:0], nibble} into the FIFO at that same edge (E2), cnt <= 0, go to IDLE.
  - COLLECT, rise && !DOutValid_s: FrameErr pulses for exactly one Clk; partial word discarded; go to IDLE.
  - RxActive = (state==COLLECT).
- FIFO:
  - Circular buffer with a read pointer, a write pointer and Level.
  - WordOut is driven from the buffer at the read pointer; WordValid = (Level!=0).
  - Pop = WordValid && WordReady.
  - Push when Level<DEPTH: accepted.
  - Push when Level==DEPTH with no pop in the same cycle: word dropped, Overflow pulses for one cycle, contents unchanged.
  - Push and pop in the same cycle:
    - Both succeed, including when full and when Level==1.
    - Level is unchanged.
    - The new word appears at the head only after all older words.
  - Pop when empty: no effect; WordOut holds its last value.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Final-nibble ClkTx rise (first Clk edge sampling it = E0) to WordValid=1 with an empty FIFO: WordValid is registered high after E2.
  - WordOut is valid in the same cycle WordValid rises.
- Consecutive frames:
  - DOutValid may stay high across back-to-back words.
  - Each group of NIBBLES rises forms one word, with no gap required.

Test Plan:
- Reset, then 4 ClkTx cycles with DOutValid=1 carrying A,5,C,3 -> one word 0xA5C3; WordValid rises at E2 after the last ClkTx rise; Level=1; FrameErr=0.
- Back-to-back frames 0x1234 and 0xFEDC with DOutValid held high and WordReady=1 -> WordOut 0x1234 then 0xFEDC in order; no FrameErr.
- Frame aborted: 2 nibbles (7,8), then a rise with DOutValid=0 -> FrameErr pulses once, Level stays 0; next full frame 0x0F0F is received intact.
- WordReady=0, 5 frames 0x0001..0x0005 -> Level=4, one Overflow pulse on the 5th; draining yields 0x0001..0x0004 and Level returns to 0.
- FIFO full (Level=4), WordReady=1 in the same cycle a word completes -> no Overflow; Level stays 4; order is preserved through a full drain.
- Reset asserted after 3 of 4 nibbles, then released -> RxActive=0, Level=0; the next frame 0xBEEF is received correctly with no stale nibbles.

Source files
------------

// File: rtl/dataout_rx.sv
// Receiver for the core's serial nibble result port: synchronizes the ClkTx/DOutValid/DataOut
// stream into Clk, reassembles MSB-first nibbles into words and buffers them in a small FIFO.
module dataout_rx #(
   parameter int NIBBLES = 4,
   parameter int DEPTH   = 4,
   localparam int W      = 4 * NIBBLES,
   localparam int LW     = $clog2(DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          ClkTx,
   input  logic          DOutValid,
   input  logic [3:0]    DataOut,
   output logic [W-1:0]  WordOut,
   output logic          WordValid,
   input  logic          WordReady,
   output logic [LW-1:0] Level,
   output logic          RxActive,
   output logic          FrameErr,
   output logic          Overflow
);

   localparam int CW = $clog2(NIBBLES + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t          state, state_nxt;
   logic            clk_tx_s1, clk_tx_s2, clk_tx_s3;
   logic            vld_s1, vld_s2;
   logic [3:0]      data_s1, data_s2;
   logic            rise;
   logic [W-1:0]    shift, shift_nxt;
   logic [W+3:0]    cat;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            push, frame_err_nxt;
   logic            pop, wr_ok, overflow_nxt;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [W-1:0]    mem [DEPTH];

   // Two-flop synchronizers; ClkTx gets a third flop for edge detection.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         clk_tx_s1 <= 1'b0;
         clk_tx_s2 <= 1'b0;
         clk_tx_s3 <= 1'b0;
         vld_s1    <= 1'b0;
         vld_s2    <= 1'b0;
         data_s1   <= '0;
         data_s2   <= '0;
      end else begin
         clk_tx_s1 <= ClkTx;
         clk_tx_s2 <= clk_tx_s1;
         clk_tx_s3 <= clk_tx_s2;
         vld_s1    <= DOutValid;
         vld_s2    <= vld_s1;
         data_s1   <= DataOut;
         data_s2   <= data_s1;
      end
   end

   assign rise = clk_tx_s2 && !clk_tx_s3;
   assign cat  = {shift, data_s2};

   always_comb begin
      state_nxt     = state;
      shift_nxt     = shift;
      cnt_nxt       = cnt;
      push          = 1'b0;
      frame_err_nxt = 1'b0;
      if (rise) begin
         case (state)
            IDLE: begin
               if (vld_s2) begin
                  if (NIBBLES == 1) begin
                     push = 1'b1;
                  end else begin
                     shift_nxt = W'(data_s2);
                     cnt_nxt   = CW'(1);
                     state_nxt = COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (!vld_s2) begin
                  frame_err_nxt = 1'b1;
                  cnt_nxt       = '0;
                  state_nxt     = IDLE;
               end else if (cnt == LAST) begin
                  push      = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  shift_nxt = cat[W-1:0];
                  cnt_nxt   = cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         shift    <= '0;
         cnt      <= '0;
         FrameErr <= 1'b0;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         cnt      <= cnt_nxt;
         FrameErr <= frame_err_nxt;
      end
   end

   assign RxActive = (state == COLLECT);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign WordValid    = (Level != '0);
   assign WordOut      = mem[rd_ptr];
   assign pop          = WordValid && WordReady;
   assign wr_ok        = push && ((Level != FULL) || pop);
   assign overflow_nxt = push && (Level == FULL) && !pop;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         Level    <= '0;
         Overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         Overflow <= overflow_nxt;
         if (wr_ok) begin
            mem[wr_ptr] <= cat[W-1:0];
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr_ok && !pop)      Level <= Level + 1'b1;
         else if (pop && !wr_ok) Level <= Level - 1'b1;
      end
   end

endmodule
